vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive-side counterpart of the video timing generator and bitmap reader.
- Takes a raw hsync/vsync/pixel stream, recovers line and frame position from the syncs, and measures the incoming timing.
- Packs a 320x200 window of 1-bit pixels MSB-first into bytes and writes them through the bitmap memory's write port: WE, Address, DataIn.
- Sits between an external video source (or a looped-back generator output) and the bitmap RAM.

Parameters:
- X_START, 49: clocks from synchronized hsync rising edge to active pixel 0.
- Y_START, 3: hsync rising edges from synchronized vsync rising edge to active line 0.
- DELTA_LEFT, 46: active pixels skipped before the capture window.
- DELTA_TOP, 62: active lines skipped before the capture window.
- CAP_W, 320: capture width in pixels; must be a multiple of 8.
- CAP_H, 200: capture height in lines.
- BYTES_PER_LINE, 40: CAP_W/8; the address row stride.

Ports:
- clk, in, 1: pixel clock; one pixel per clock.
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: arm capture; sampled only at frame start.
- hsync_in, in, 1: horizontal sync, active-low pulse, asynchronous.
- vsync_in, in, 1: vertical sync, active-low pulse, asynchronous.
- pixel_in, in, 1: pixel data, asynchronous.
- we, out, 1: bitmap write strobe.
- address, out, 14: bitmap byte address.
- data_in, out, 8: byte to write; bit 7 is the leftmost pixel.
- frame_done, out, 1: one-cycle pulse after the last byte of a complete frame.
- frame_err, out, 1: one-cycle pulse when a capture is aborted.
- locked, out, 1: timing stable.
- line_len, out, 10: clocks between consecutive hsync falling edges.
- frame_lines, out, 10: hsync falls between consecutive vsync falls.

Behaviour:
- Reset: every output 0; FSM in IDLE; counters, shift register and measurements cleared. A reset mid-frame drops any partial byte and writes nothing further.
- Input conditioning: hsync_in, vsync_in and pixel_in each pass through a 2-flop synchronizer, so all three share the same 2-clock delay. Edge detection runs on the synchronized signals.
- Measurement:
  - Clock counter restarts on each hsync fall; its previous value is latched into line_len. It saturates at 1023.
  - Line counter restarts on each vsync fall; its previous value is latched into frame_lines.
  - locked is set when line_len and frame_lines both equal their previous latched values. It clears on the first mismatch.
- FSM states and transitions:
  - IDLE -> VWAIT when enable=1 at a vsync fall.
  - VWAIT -> SEEK on vsync rise.
  - SEEK: counts hsync rises; enters LINE when the count equals Y_START+DELTA_TOP.
  - LINE: on each hsync rise, wait X_START+DELTA_LEFT clocks, then shift CAP_W pixels, then idle until the next hsync rise. Returns to IDLE after line CAP_H-1 finishes.
- Packing:
  - The shift register fills MSB-first.
  - On the 8th pixel of a byte, the next cycle has we=1, data_in=that byte, and address = row*BYTES_PER_LINE + col.
  - row is 0..CAP_H-1 and col is 0..BYTES_PER_LINE-1. The product is computed at 14 bits with no wrap for the defaults (max 7999).
  - we is high for exactly one cycle per byte; CAP_W/8 writes per line.
- frame_done: pulses on the cycle after the final write (address 7999).
- Boundary conditions:
  - hsync fall during the pixel-shift window: partial byte discarded, frame_err pulses, FSM -> IDLE.
  - vsync fall while in SEEK or LINE: frame_err pulses, FSM -> IDLE, and that same vsync fall is evaluated as a new frame start.
  - enable deasserted mid-frame: the current frame completes; no new frame is armed.
  - Line shorter than X_START+DELTA_LEFT+CAP_W: handled as an hsync fall in the shift window.
  - Simultaneous hsync fall and vsync fall: the vsync rule takes priority; the line counter still increments first.

Decomposition:
- Shared package video_pkg holds the timing constants shared with the generator: visible/front/pulse/back and the delta_* window offsets. It also holds CAP_W, CAP_H, BYTES_PER_LINE and the FSM state enum.
- One sub-module, sync_edge: 2-flop synchronizer plus rise/fall pulse outputs. Instantiated for hsync and vsync; pixel uses the synchronizer only.

Test Plan:
- Loopback: drive from the generator at 512x312 total timing with a checkerboard of 0xAA bytes -> exactly 8000 writes, every data_in=0xAA, addresses 0..7999 ascending, one frame_done, frame_err=0.
- Locking: two identical frames -> line_len=512 and frame_lines=312 after the first frame; locked=1 after the second frame's vsync fall. Change the line length to 500 -> locked=0 on the next hsync fall.
- Pixel placement: a single pixel at window position (x=9, y=3) -> a write with address=3*40+1=121 and data_in=0x40; all other written bytes are 0x00.
- Early hsync: cut line 10 short after 100 window pixels -> no write at address 412, frame_err pulses once, FSM returns to IDLE, the next frame captures fully.
- Enable gating: enable=0 at vsync fall -> zero writes that frame. Raise enable mid-frame -> capture starts only at the next vsync.
- Reset mid-line: assert rst for 1 cycle during row 50 -> we=0 and all outputs 0 the following cycle; the capture restarts at the next armed vsync.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: timing constants, capture window geometry and capture FSM states shared by the video blocks
package video_pkg;
  localparam int H_VISIBLE = 400;
  localparam int H_FRONT = 15;
  localparam int H_PULSE = 48;
  localparam int H_BACK = 49;
  localparam int V_VISIBLE = 280;
  localparam int V_FRONT = 10;
  localparam int V_PULSE = 19;
  localparam int V_BACK = 3;
  localparam int X_START = H_BACK;
  localparam int Y_START = V_BACK;
  localparam int DELTA_LEFT = 46;
  localparam int DELTA_TOP = 62;
  localparam int CAP_W = 320;
  localparam int CAP_H = 200;
  localparam int BYTES_PER_LINE = CAP_W / 8;
  typedef enum logic [1:0] {IDLE, VWAIT, SEEK, LINE} cap_state_t;
  function automatic logic [13:0] byte_addr(input logic [9:0] row, input logic [9:0] col, input int bpl);
    return 14'(int'(row) * bpl + int'(col));
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer with rise/fall pulses on the synchronized level
module sync_edge #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise,
  output logic fall
);
  logic s1_q, s2_q, prev_q;
  // two synchronizer stages plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= INIT;
      s2_q <= INIT;
      prev_q <= INIT;
    end else begin
      s1_q <= d_in;
      s2_q <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;
endmodule

// File: rtl/vga_capture.sv
// vga_capture: recovers sync timing from a raw video stream and writes a 1-bpp capture window into bitmap RAM
module vga_capture #(
  parameter int X_START = video_pkg::X_START,
  parameter int Y_START = video_pkg::Y_START,
  parameter int DELTA_LEFT = video_pkg::DELTA_LEFT,
  parameter int DELTA_TOP = video_pkg::DELTA_TOP,
  parameter int CAP_W = video_pkg::CAP_W,
  parameter int CAP_H = video_pkg::CAP_H,
  parameter int BYTES_PER_LINE = CAP_W / 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        pixel_in,
  output logic        we,
  output logic [13:0] address,
  output logic [7:0]  data_in,
  output logic        frame_done,
  output logic        frame_err,
  output logic        locked,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines
);
  import video_pkg::*;
  localparam logic [9:0] WIN_S = 10'(X_START + DELTA_LEFT);
  localparam logic [9:0] WIN_E = 10'(X_START + DELTA_LEFT + CAP_W);
  localparam logic [9:0] SEEK_N = 10'(Y_START + DELTA_TOP);
  localparam logic [9:0] ROW_LAST = 10'(CAP_H - 1);
  localparam logic [9:0] SAT = 10'h3ff;
  localparam logic [13:0] LAST_ADDR = 14'(CAP_H * BYTES_PER_LINE - 1);
  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic pix1_q, pix_q;
  logic [9:0] clk_cnt_q, clk_cnt_d, line_cnt_q, line_cnt_d, line_inc;
  logic [9:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic ll_ok_q, ll_ok_d, locked_q, locked_d;
  cap_state_t state_q, state_d;
  logic [9:0] pos_q, pos_d, row_q, row_d, seek_q, seek_d, j;
  logic [6:0] sr_q, sr_d;
  logic [7:0] data_q, data_d;
  logic [13:0] addr_q, addr_d;
  logic we_q, we_d, done_q, done_d, err_q, err_d, in_win;
  sync_edge #(.INIT(1'b1)) u_hs (.clk(clk), .rst(rst), .d_in(hsync_in), .rise(hs_rise), .fall(hs_fall));
  sync_edge #(.INIT(1'b1)) u_vs (.clk(clk), .rst(rst), .d_in(vsync_in), .rise(vs_rise), .fall(vs_fall));
  // pixel gets the same two-stage delay as the syncs so positions line up
  always_ff @(posedge clk) begin
    if (rst) begin
      pix1_q <= 1'b0;
      pix_q <= 1'b0;
    end else begin
      pix1_q <= pixel_in;
      pix_q <= pix1_q;
    end
  end
  // line/frame measurement; a coincident hsync fall is counted before the vsync fall latches the total
  always_comb begin
    line_inc = (hs_fall && line_cnt_q != SAT) ? line_cnt_q + 10'd1 : line_cnt_q;
    clk_cnt_d = hs_fall ? 10'd1 : (clk_cnt_q == SAT ? clk_cnt_q : clk_cnt_q + 10'd1);
    line_len_d = hs_fall ? clk_cnt_q : line_len_q;
    ll_ok_d = hs_fall ? (clk_cnt_q == line_len_q) : ll_ok_q;
    line_cnt_d = vs_fall ? 10'd0 : line_inc;
    frame_lines_d = vs_fall ? line_inc : frame_lines_q;
    locked_d = vs_fall ? (line_inc == frame_lines_q && ll_ok_d) : (hs_fall && !ll_ok_d) ? 1'b0 : locked_q;
  end
  assign in_win = state_q == LINE && pos_q >= WIN_S && pos_q < WIN_E;
  assign j = pos_q - WIN_S;
  // capture FSM; a vsync fall aborts and re-arms from any state, ahead of every other rule
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    row_d = row_q;
    seek_d = seek_q;
    sr_d = sr_q;
    data_d = data_q;
    addr_d = addr_q;
    we_d = 1'b0;
    err_d = 1'b0;
    done_d = we_q && addr_q == LAST_ADDR;
    if (vs_fall) begin
      err_d = state_q == SEEK || state_q == LINE;
      state_d = enable ? VWAIT : IDLE;
    end else if (state_q == VWAIT && vs_rise) begin
      state_d = SEEK;
      seek_d = 10'd0;
    end else if (state_q == SEEK && hs_rise) begin
      seek_d = seek_q + 10'd1;
      state_d = (seek_d == SEEK_N) ? LINE : SEEK;
      pos_d = WIN_E;
      row_d = 10'd0;
    end else if (state_q == LINE) begin
      if (in_win && hs_fall) begin
        err_d = 1'b1;
        state_d = IDLE;
      end else if (hs_rise) begin
        pos_d = 10'd1;
      end else if (in_win) begin
        sr_d = {sr_q[5:0], pix_q};
        pos_d = pos_q + 10'd1;
        if (j[2:0] == 3'd7) begin
          we_d = 1'b1;
          data_d = {sr_q, pix_q};
          addr_d = byte_addr(row_q, {3'b000, j[9:3]}, BYTES_PER_LINE);
        end
        if (pos_q == WIN_E - 10'd1) begin
          row_d = row_q + 10'd1;
          state_d = (row_q == ROW_LAST) ? IDLE : LINE;
        end
      end else if (pos_q < WIN_S) begin
        pos_d = pos_q + 10'd1;
      end
    end
  end
  // all state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_q <= '0;
      line_cnt_q <= '0;
      line_len_q <= '0;
      frame_lines_q <= '0;
      ll_ok_q <= 1'b0;
      locked_q <= 1'b0;
      state_q <= IDLE;
      pos_q <= '0;
      row_q <= '0;
      seek_q <= '0;
      sr_q <= '0;
      data_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      line_cnt_q <= line_cnt_d;
      line_len_q <= line_len_d;
      frame_lines_q <= frame_lines_d;
      ll_ok_q <= ll_ok_d;
      locked_q <= locked_d;
      state_q <= state_d;
      pos_q <= pos_d;
      row_q <= row_d;
      seek_q <= seek_d;
      sr_q <= sr_d;
      data_q <= data_d;
      addr_q <= addr_d;
      we_q <= we_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign we = we_q;
  assign address = addr_q;
  assign data_in = data_q;
  assign frame_done = done_q;
  assign frame_err = err_q;
  assign locked = locked_q;
  assign line_len = line_len_q;
  assign frame_lines = frame_lines_q;
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: random-image frames against a window model, scoreboarded write checks
module tb_vga_capture;
  localparam int XS = 4, YS = 2, DL = 3, DT = 2, CW = 16, CH = 6, BPL = CW / 8;
  localparam int HP = 4, VP = 2, LL = 40, FL = 14;
  localparam int X0 = HP + XS + DL;
  localparam int ROW0 = VP + YS + DT;
  localparam int LAST = CH * BPL - 1;
  localparam int NONE = 1000;
  typedef struct {
    logic [13:0] a;
    logic [7:0] d;
  } wr_t;
  logic clk, rst, enable, hsync_in, vsync_in, pixel_in;
  logic we, frame_done, frame_err, locked;
  logic [13:0] address;
  logic [7:0] data_in;
  logic [9:0] line_len, frame_lines;
  wr_t exp_q[$];
  bit img[CH][CW];
  int total = 0, bad = 0;
  int n_done = 0, n_err = 0, exp_done = 0, exp_err = 0;
  bit prev_last = 0;

  vga_capture #(.X_START(XS), .Y_START(YS), .DELTA_LEFT(DL), .DELTA_TOP(DT), .CAP_W(CW), .CAP_H(CH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_in(pixel_in),
    .we(we), .address(address), .data_in(data_in), .frame_done(frame_done), .frame_err(frame_err),
    .locked(locked), .line_len(line_len), .frame_lines(frame_lines)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int y, input int c);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[7-k] = img[y][8*c+k];
    return b;
  endfunction

  task automatic check_idle_outputs();
    check("rst_we", we, 0);
    check("rst_address", address, 0);
    check("rst_data", data_in, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_locked", locked, 0);
    check("rst_line_len", line_len, 0);
    check("rst_frame_lines", frame_lines, 0);
  endtask

  always @(negedge clk) begin
    if (we) begin
      if (exp_q.size() == 0) check("unexpected_write", we, 0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", address, e.a);
        check("write_data", data_in, e.d);
      end
    end
    if (frame_done) begin
      n_done++;
      check("done_after_last_write", prev_last, 1);
    end
    if (frame_err) n_err++;
    prev_last = we && address == 14'(LAST);
  end

  task automatic run_frame(input int mode, input int fl, input int ll, input int sl, input int sl_len,
                           input int rl, input bit en, input bit en_after);
    int len, x, y, avail, nb;
    for (int yy = 0; yy < CH; yy++)
      for (int xx = 0; xx < CW; xx++)
        img[yy][xx] = mode == 1 ? (xx % 2 == 0) : mode == 2 ? (yy == 3 && xx == 9) : bit'($urandom_range(0, 1));
    if (en) begin
      for (int r = 0; r < CH; r++) begin
        y = ROW0 + r;
        if (y >= rl) break;
        if (y >= fl) begin
          exp_err++;
          break;
        end
        avail = ((y == sl) ? sl_len : ll) - X0;
        nb = avail >= CW ? BPL : avail / 8;
        for (int c = 0; c < nb; c++) exp_q.push_back('{a: 14'(r * BPL + c), d: exp_byte(r, c)});
        if (nb < BPL) begin
          exp_err++;
          break;
        end
        if (r == CH - 1) exp_done++;
      end
    end
    for (int l = 0; l < fl; l++) begin
      len = (l == sl) ? sl_len : ll;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if (l == rl && c == 1) check_idle_outputs();
        rst = (l == rl && c == 0);
        if (c == 0 && l == 0) enable = en;
        if (c == 0 && l == 1) enable = en_after;
        hsync_in = c >= HP;
        vsync_in = l >= VP;
        x = c - X0;
        y = l - ROW0;
        pixel_in = (y >= 0 && y < CH && x >= 0 && x < CW) ? img[y][x] : 1'($urandom_range(0, 1));
      end
    end
    check("queue_drained", exp_q.size(), 0);
    check("done_count", n_done, exp_done);
  endtask

  initial begin
    rst = 1;
    enable = 0;
    hsync_in = 1;
    vsync_in = 1;
    pixel_in = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs();
    rst = 0;
    repeat (5) @(negedge clk);
    run_frame(1, FL, LL, NONE, 0, NONE, 1, 1);
    run_frame(2, FL, LL, NONE, 0, NONE, 1, 1);
    run_frame(0, FL, LL, NONE, 0, NONE, 1, 1);
    check("locked_stable", locked, 1);
    check("line_len_40", line_len, LL);
    check("frame_lines_14", frame_lines, FL);
    run_frame(0, FL, 38, NONE, 0, NONE, 1, 1);
    check("locked_lost", locked, 0);
    check("line_len_38", line_len, 38);
    check("frame_lines_kept", frame_lines, FL);
    run_frame(0, FL, LL, ROW0 + 2, X0 + 10, NONE, 1, 1);
    check("err_early_hsync", n_err, exp_err);
    run_frame(0, FL, LL, NONE, 0, NONE, 1, 1);
    run_frame(0, FL, LL, NONE, 0, NONE, 0, 1);
    run_frame(0, FL, LL, NONE, 0, NONE, 1, 1);
    run_frame(0, 9, LL, NONE, 0, NONE, 1, 1);
    run_frame(0, FL, LL, NONE, 0, NONE, 1, 1);
    run_frame(0, FL, LL, NONE, 0, ROW0 + 3, 1, 1);
    run_frame(0, FL, LL, NONE, 0, NONE, 1, 1);
    hsync_in = 1;
    vsync_in = 1;
    repeat (20) @(negedge clk);
    check("final_queue", exp_q.size(), 0);
    check("final_done", n_done, exp_done);
    check("final_err", n_err, exp_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
